// File: rtl/cpu_mem_copy_master.sv
// Avalon-MM master that copies a block of words or fills it with a constant,
// one command at a time, on the CPU on-chip memory port.
module cpu_mem_copy_master #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                fill_mode,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    len,
  input  logic [DATA_W-1:0]   fill_value,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_chipselect,
  output logic                m_read,
  output logic                m_write,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_waitrequest
);

  localparam int LAT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RWAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                fill_q, fill_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;

  assign accept = (rd_q | wr_q) & ~m_waitrequest;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    wdata_d = wdata_q;
    lat_d   = lat_q;
    addr_d  = addr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          rem_d  = len;
          fill_d = fill_mode;
          if (fill_mode) wdata_d = fill_value;
          if (len == '0)     state_d = S_DONE;
          else if (fill_mode) state_d = S_WR;
          else               state_d = S_RD;
        end
      end
      S_RD: begin
        if (accept) begin
          state_d = S_RWAIT;
          lat_d   = LAT_W'(READ_LATENCY - 1);
        end
      end
      S_RWAIT: begin
        // Read data is valid in the last RWAIT cycle; capture it on the closing edge.
        if (lat_q == '0) begin
          wdata_d = m_readdata;
          state_d = S_WR;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      S_WR: begin
        if (accept) begin
          rem_d = rem_q - LEN_W'(1);
          src_d = src_q + ADDR_W'(1);
          dst_d = dst_q + ADDR_W'(1);
          if (rem_q == LEN_W'(1)) state_d = S_DONE;
          else if (fill_q)        state_d = S_WR;
          else                    state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    rd_d   = (state_d == S_RD);
    wr_d   = (state_d == S_WR);
    busy_d = rd_d | wr_d | (state_d == S_RWAIT);
    done_d = (state_d == S_DONE);
    if (rd_d)      addr_d = src_d;
    else if (wr_d) addr_d = dst_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
      wdata_q <= '0;
      lat_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      wdata_q <= wdata_d;
      lat_q   <= lat_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign m_address    = addr_q;
  assign m_byteenable = '1;
  assign m_chipselect = rd_q | wr_q;
  assign m_read       = rd_q;
  assign m_write      = wr_q;
  assign m_writedata  = wdata_q;

endmodule

// File: tb/tb_cpu_mem_copy_master.sv
// Self-checking bench for cpu_mem_copy_master: a memory slave model plus a
// block-level reference model of copy/fill results, timing and bus addresses.
module tb_cpu_mem_copy_master;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 12;
  localparam int RL     = 1;
  localparam int DEPTH  = 2048;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              fill_mode;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] m_address;
  logic [3:0]        m_byteenable;
  logic              m_chipselect;
  logic              m_read;
  logic              m_write;
  logic [DATA_W-1:0] m_writedata;
  logic [DATA_W-1:0] m_readdata;
  logic              m_waitrequest;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  typedef struct {
    string             name;
    logic              fm;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] fv;
    int                stall_mode;
    bit                poke;
    int                exp_busy;
  } vec_t;

  vec_t vecs[$];

  cpu_mem_copy_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .fill_mode(fill_mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_value(fill_value),
    .busy(busy), .done(done), .m_address(m_address), .m_byteenable(m_byteenable),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Memory slave with fixed read latency of one cycle; junk data otherwise.
  always @(posedge clk) begin
    if (m_write === 1'b1 && m_waitrequest === 1'b0) mem[m_address] = m_writedata;
    if (m_read === 1'b1 && m_waitrequest === 1'b0) m_readdata <= mem[m_address];
    else m_readdata <= $urandom;
  end

  // Bus protocol monitor: stalled requests must hold, strobes stay consistent.
  logic              p_rd, p_wr, p_wait, p_rst;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wd;

  always @(posedge clk) begin
    p_rd   = m_read;
    p_wr   = m_write;
    p_wait = m_waitrequest;
    p_rst  = reset;
    p_addr = m_address;
    p_wd   = m_writedata;
    #1;
    if (p_rst === 1'b0) begin
      if ((p_rd | p_wr) && p_wait) begin
        checkOutput("stall_read_hold", 32'(m_read), 32'(p_rd));
        checkOutput("stall_write_hold", 32'(m_write), 32'(p_wr));
        checkOutput("stall_addr_hold", 32'(m_address), 32'(p_addr));
        checkOutput("stall_wdata_hold", m_writedata, p_wd);
      end
      checkOutput("rd_wr_exclusive", 32'(m_read & m_write), 32'd0);
      checkOutput("chipselect", 32'(m_chipselect), 32'(m_read | m_write));
      checkOutput("byteenable", 32'(m_byteenable), 32'hF);
    end
  end

  task automatic applyStimulus(input logic fm, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                               input logic [LEN_W-1:0] n, input logic [DATA_W-1:0] fv);
    @(negedge clk);
    fill_mode     = fm;
    src_addr      = s;
    dst_addr      = d;
    len           = n;
    fill_value    = fv;
    m_waitrequest = 1'b0;
    start         = 1'b1;
  endtask

  task automatic runCommand(input string name, input logic fm, input logic [ADDR_W-1:0] s,
                            input logic [ADDR_W-1:0] d, input logic [LEN_W-1:0] n,
                            input logic [DATA_W-1:0] fv, input int stall_mode, input bit poke,
                            input int exp_busy);
    logic [ADDR_W-1:0] exp_wr[$], exp_rd[$], got_wr[$], got_rd[$];
    int busy_cycles = 0, stalls = 0, done_cycle = 0, rd_stall_n = 0, wr_stall_n = 0, bad = -1;
    bit got_done = 0;

    for (int i = 0; i < int'(n); i++) begin
      logic [ADDR_W-1:0] sa, da;
      sa = s + ADDR_W'(i);
      da = d + ADDR_W'(i);
      exp_wr.push_back(da);
      if (fm) ref_mem[da] = fv;
      else begin
        exp_rd.push_back(sa);
        ref_mem[da] = ref_mem[sa];
      end
    end

    applyStimulus(fm, s, d, n, fv);
    for (int cyc = 0; cyc < 20000 && !got_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        got_done   = 1;
        done_cycle = cyc + 1;
      end else begin
        if (busy === 1'b1) busy_cycles++;
        if (poke && cyc == 2) begin
          start      = 1'b1;
          fill_mode  = 1'b1;
          dst_addr   = 11'h400;
          len        = 12'd3;
          fill_value = 32'h12345678;
        end
        case (stall_mode)
          0: m_waitrequest = 1'b0;
          1: m_waitrequest = ($urandom_range(0, 3) == 0);
          default: begin
            m_waitrequest = 1'b0;
            if (m_read === 1'b1 && rd_stall_n < 3) begin
              m_waitrequest = 1'b1;
              rd_stall_n++;
            end else if (m_write === 1'b1 && rd_stall_n == 3 && wr_stall_n < 3) begin
              m_waitrequest = 1'b1;
              wr_stall_n++;
            end
          end
        endcase
        if (m_read === 1'b1 || m_write === 1'b1) begin
          if (m_waitrequest) stalls++;
          else if (m_read === 1'b1) got_rd.push_back(m_address);
          else got_wr.push_back(m_address);
        end
      end
    end
    m_waitrequest = 1'b0;

    checkOutput({name, "_done_seen"}, 32'(got_done), 32'd1);
    checkOutput({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy + stalls));
    checkOutput({name, "_done_cycle"}, 32'(done_cycle), 32'(exp_busy + stalls + 1));
    if (stall_mode == 2) checkOutput({name, "_stall_count"}, 32'(stalls), 32'd6);
    @(negedge clk);
    checkOutput({name, "_done_pulse_end"}, 32'({done, busy}), 32'd0);

    checkOutput({name, "_write_count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    checkOutput({name, "_read_count"}, 32'(got_rd.size()), 32'(exp_rd.size()));
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
      checkOutput({name, "_write_addr"}, 32'(got_wr[i]), 32'(exp_wr[i]));
      if (got_wr[i] !== exp_wr[i]) break;
    end
    for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++) begin
      checkOutput({name, "_read_addr"}, 32'(got_rd[i]), 32'(exp_rd[i]));
      if (got_rd[i] !== exp_rd[i]) break;
    end
    for (int i = 0; i < DEPTH && bad < 0; i++)
      if (mem[i] !== ref_mem[i]) bad = i;
    if (bad < 0) bad = int'(d);
    checkOutput({name, "_memory"}, mem[bad], ref_mem[bad]);
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    fill_mode     = 1'b0;
    src_addr      = '0;
    dst_addr      = '0;
    len           = '0;
    fill_value    = '0;
    m_waitrequest = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = (i < 8) ? 32'(i) * 32'h11111111 : $urandom;
      ref_mem[i] = mem[i];
    end

    vecs.push_back('{"fill_basic",   1'b1, 11'h000, 11'h010, 12'd4,    32'hDEADBEEF, 0, 1'b0, 4});
    vecs.push_back('{"copy_basic",   1'b0, 11'h000, 11'h100, 12'd8,    32'h0,        0, 1'b0, 24});
    vecs.push_back('{"copy_stall",   1'b0, 11'h000, 11'h180, 12'd8,    32'h0,        2, 1'b0, 24});
    vecs.push_back('{"fill_wrap",    1'b1, 11'h000, 11'h7FE, 12'd4,    32'hCAFEF00D, 0, 1'b0, 4});
    vecs.push_back('{"copy_wrap",    1'b0, 11'h7FF, 11'h200, 12'd2,    32'h0,        0, 1'b0, 6});
    vecs.push_back('{"fill_len0",    1'b1, 11'h000, 11'h300, 12'd0,    32'h55555555, 0, 1'b0, 0});
    vecs.push_back('{"copy_len0",    1'b0, 11'h010, 11'h300, 12'd0,    32'h0,        0, 1'b0, 0});
    vecs.push_back('{"start_busy",   1'b1, 11'h000, 11'h300, 12'd8,    32'h0BADC0DE, 0, 1'b1, 8});
    vecs.push_back('{"copy_overlap", 1'b0, 11'h100, 11'h102, 12'd6,    32'h0,        0, 1'b0, 18});
    vecs.push_back('{"fill_full",    1'b1, 11'h000, 11'h123, 12'd2048, 32'h600DF00D, 0, 1'b0, 2048});

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_read", 32'(m_read), 32'd0);
    checkOutput("reset_write", 32'(m_write), 32'd0);
    checkOutput("reset_chipselect", 32'(m_chipselect), 32'd0);
    checkOutput("reset_address", 32'(m_address), 32'd0);
    checkOutput("reset_writedata", m_writedata, 32'd0);
    checkOutput("reset_byteenable", 32'(m_byteenable), 32'hF);
    reset = 1'b0;

    foreach (vecs[k])
      runCommand(vecs[k].name, vecs[k].fm, vecs[k].src, vecs[k].dst, vecs[k].len,
                 vecs[k].fv, vecs[k].stall_mode, vecs[k].poke, vecs[k].exp_busy);

    // Reset during the third write of a fill, with that write stalled.
    applyStimulus(1'b1, 11'h000, 11'h500, 12'd8, 32'hA5A50000);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 2) begin
        m_waitrequest = 1'b1;
        reset         = 1'b1;
      end
    end
    ref_mem[11'h500] = 32'hA5A50000;
    ref_mem[11'h501] = 32'hA5A50000;
    @(negedge clk);
    checkOutput("abort_write", 32'(m_write), 32'd0);
    checkOutput("abort_read", 32'(m_read), 32'd0);
    checkOutput("abort_chipselect", 32'(m_chipselect), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    reset         = 1'b0;
    m_waitrequest = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checkOutput("abort_quiet", 32'({done, busy, m_chipselect}), 32'd0);
    end
    runCommand("after_abort", 1'b0, 11'h500, 11'h600, 12'd4, 32'h0, 0, 1'b0, 12);

    // Randomized commands with random waitrequest against the block-level model.
    for (int r = 0; r < 20; r++) begin
      logic              fm;
      logic [ADDR_W-1:0] s, d;
      logic [LEN_W-1:0]  n;
      fm = 1'($urandom_range(0, 1));
      s  = ADDR_W'($urandom);
      d  = ADDR_W'($urandom);
      n  = LEN_W'($urandom_range(0, 40));
      runCommand("random", fm, s, d, n, $urandom, 1, 1'b0,
                 fm ? int'(n) : (2 + RL) * int'(n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
